// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display path:
// the hex glyph table, the "all dark" output codes, the scan states,
// and a small helper that turns a digit index into an anode pattern.
package seven_seg_pkg;

  // Segments off (active-low) and all anodes off (active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low glyphs {g,f,e,d,c,b,a} for 0-F. The DP bit is driven
  // separately, so the table carries only the seven segment bits.
  // With the DP dark these read as C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Scan states: dark guard interval, then the digit is lit.
  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_e;

  // Active-low one-hot anode enable for digit position idx.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    anode_sel = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex-to-seven-segment decoder, active-low {g,f,e,d,c,b,a}.
// Shared with the single-digit display path, so it carries no DP logic.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Straight table lookup; every nibble value has a glyph.
  always_comb begin
    seg_o = SEG_HEX[hex_i];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode scanner. Nibbles, DP and blank masks are captured
// into a shadow buffer on load and promoted to the active buffer only at a
// frame boundary, so a frame on the glass is never a mix of old and new data.
// Each digit gets a dark guard interval before it is lit to avoid ghosting.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int ON_CYCLES    = 95000,
  parameter int BLANK_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic             HAS_GUARD  = (BLANK_CYCLES > 0);
  localparam state_e           RESET_STATE = HAS_GUARD ? S_BLANK : S_ON;

  // Scan sequencer state.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             frameEnd;

  // Shadow (written by load) and active (shown on the display) buffers.
  logic [15:0] shadowDigits_q, shadowDigits_d;
  logic [3:0]  shadowDp_q, shadowDp_d;
  logic [3:0]  shadowBlank_q, shadowBlank_d;
  logic [15:0] activeDigits_q, activeDigits_d;
  logic [3:0]  activeDp_q, activeDp_d;
  logic [3:0]  activeBlank_q, activeBlank_d;
  logic        pending_q, pending_d;

  // Output registers.
  logic [3:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] nextNibble;
  logic [6:0] nextGlyph;

  // Advance the guard/lit timer; the counter restarts on every slot change,
  // and frameEnd marks the edge where the digit index wraps from 3 to 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    frameEnd = 1'b0;
    if (state_q == S_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = S_ON;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == ON_LAST) begin
        state_d  = HAS_GUARD ? S_BLANK : S_ON;
        cnt_d    = '0;
        idx_d    = idx_q + 2'd1;
        frameEnd = (idx_q == 2'd3);
      end
    end
  end

  // Double buffering: load always refreshes the shadow; the active copy only
  // changes at a frame end, taking the inputs directly if load lands there.
  always_comb begin
    shadowDigits_d = shadowDigits_q;
    shadowDp_d     = shadowDp_q;
    shadowBlank_d  = shadowBlank_q;
    activeDigits_d = activeDigits_q;
    activeDp_d     = activeDp_q;
    activeBlank_d  = activeBlank_q;
    pending_d      = pending_q;

    if (load) begin
      shadowDigits_d = digits_in;
      shadowDp_d     = dp_in;
      shadowBlank_d  = blank_in;
    end

    if (frameEnd) begin
      if (load) begin
        activeDigits_d = digits_in;
        activeDp_d     = dp_in;
        activeBlank_d  = blank_in;
      end else if (pending_q) begin
        activeDigits_d = shadowDigits_q;
        activeDp_d     = shadowDp_q;
        activeBlank_d  = shadowBlank_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  assign nextNibble = activeDigits_d[{idx_d, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex_i (nextNibble),
    .seg_o (nextGlyph)
  );

  // Compute the display for the upcoming slot so anode and segments are
  // registered together and can never disagree for a cycle.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_d == S_ON && !activeBlank_d[idx_d]) begin
      an_d  = anode_sel(idx_d);
      seg_d = {~activeDp_d[idx_d], nextGlyph};
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Buffer registers; the active blank mask starts all-ones so nothing
  // lights before the first load has reached the active copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadowDigits_q <= 16'h0000;
      shadowDp_q     <= 4'h0;
      shadowBlank_q  <= 4'hF;
      activeDigits_q <= 16'h0000;
      activeDp_q     <= 4'h0;
      activeBlank_q  <= 4'hF;
      pending_q      <= 1'b0;
    end else begin
      shadowDigits_q <= shadowDigits_d;
      shadowDp_q     <= shadowDp_d;
      shadowBlank_q  <= shadowBlank_d;
      activeDigits_q <= activeDigits_d;
      activeDp_q     <= activeDp_d;
      activeBlank_q  <= activeBlank_d;
      pending_q      <= pending_d;
    end
  end

  // Output registers; reset darkens the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised bench for seven_seg_scanner with short timing (4 lit, 2 dark).
// Expected outputs come from a position-in-frame reference model.
module tb_seven_seg_scanner;

  localparam int ON    = 4;
  localparam int BLK   = 2;
  localparam int DIGIT = ON + BLK;
  localparam int FRAME = 4 * DIGIT;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  // Reference model: buffers plus the number of edges since reset.
  logic [15:0] mShDig, mActDig;
  logic [3:0]  mShDp, mActDp, mShBl, mActBl;
  logic        mPend;
  int          mEdge;
  logic [3:0]  expAn;
  logic [7:0]  expSeg;

  logic [7:0] segTab [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seven_seg_scanner #(
    .ON_CYCLES    (ON),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic modelReset();
    mShDig = 16'h0; mShDp = 4'h0; mShBl = 4'hF;
    mActDig = 16'h0; mActDp = 4'h0; mActBl = 4'hF;
    mPend = 1'b0;
    mEdge = 0;
  endtask

  // Expected display: position within the frame selects digit and phase.
  task automatic computeExpected();
    int pos, dg, ph;
    logic [3:0] nib;
    pos = mEdge % FRAME;
    dg  = pos / DIGIT;
    ph  = pos % DIGIT;
    expAn  = 4'hF;
    expSeg = 8'hFF;
    if (ph >= BLK && !mActBl[dg]) begin
      expAn  = 4'hF ^ (4'b0001 << dg);
      nib    = mActDig[dg*4 +: 4];
      expSeg = segTab[nib];
      if (mActDp[dg]) expSeg[7] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and
  // leave the bench 1 time unit after the edge ready to sample.
  task automatic applyStimulus(input logic ld, input logic [15:0] d,
                               input logic [3:0] dp, input logic [3:0] bl);
    bit boundary;
    load = ld; digits_in = d; dp_in = dp; blank_in = bl;
    @(posedge clk);
    mEdge++;
    boundary = (mEdge % FRAME == 0);
    if (boundary) begin
      if (ld) begin
        mActDig = d; mActDp = dp; mActBl = bl;
        mShDig = d;  mShDp = dp;  mShBl = bl;
      end else if (mPend) begin
        mActDig = mShDig; mActDp = mShDp; mActBl = mShBl;
      end
      mPend = 1'b0;
    end else if (ld) begin
      mShDig = d; mShDp = dp; mShBl = bl;
      mPend = 1'b1;
    end
    computeExpected();
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  // Step unchecked until the most recent edge sits at frame position p.
  task automatic advanceTo(input int p);
    for (int i = 0; i < FRAME && (mEdge % FRAME) != p; i++) idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; digits_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (an !== 4'hF) begin errors++; $display("[TB] FAIL reset_an got=%h exp=f", an); end
    if (seg !== 8'hFF) begin errors++; $display("[TB] FAIL reset_seg got=%h exp=ff", seg); end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      idle();
      checks += 2;
      if (an !== 4'hF) begin errors++; $display("[TB] FAIL idle_an edge=%0d got=%h exp=f", mEdge, an); end
      if (seg !== 8'hFF) begin errors++; $display("[TB] FAIL idle_seg edge=%0d got=%h exp=ff", mEdge, seg); end
    end
  endtask

  task automatic test_pattern();
    logic [3:0] cAn [0:3];
    logic [7:0] cSeg [0:3];
    int pos;
    cAn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    cSeg = '{8'h8E, 8'hB0, 8'h88, 8'hF9};
    idle();
    applyStimulus(1'b1, 16'h1A3F, 4'h0, 4'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      pos = mEdge % FRAME;
      checks += 2;
      if (an !== expAn) begin errors++; $display("[TB] FAIL pattern_an edge=%0d got=%h exp=%h", mEdge, an, expAn); end
      if (seg !== expSeg) begin errors++; $display("[TB] FAIL pattern_seg edge=%0d got=%h exp=%h", mEdge, seg, expSeg); end
      if (i >= FRAME) begin
        checks++;
        if (pos % DIGIT < BLK) begin
          if ({an, seg} !== {4'hF, 8'hFF}) begin errors++; $display("[TB] FAIL pattern_guard pos=%0d got=%h/%h exp=f/ff", pos, an, seg); end
        end else if ({an, seg} !== {cAn[pos / DIGIT], cSeg[pos / DIGIT]}) begin
          errors++;
          $display("[TB] FAIL pattern_const pos=%0d got=%h/%h exp=%h/%h", pos, an, seg, cAn[pos / DIGIT], cSeg[pos / DIGIT]);
        end
      end
    end
  endtask

  task automatic test_dp();
    logic [7:0] cSeg [0:3];
    int pos;
    cSeg = '{8'h0E, 8'hB0, 8'h08, 8'hF9};
    advanceTo(FRAME - 1);
    applyStimulus(1'b1, 16'h1A3F, 4'b0101, 4'h0);
    for (int i = 0; i < FRAME - 1; i++) begin
      idle();
      pos = mEdge % FRAME;
      checks += 2;
      if (an !== expAn) begin errors++; $display("[TB] FAIL dp_an edge=%0d got=%h exp=%h", mEdge, an, expAn); end
      if (seg !== expSeg) begin errors++; $display("[TB] FAIL dp_seg edge=%0d got=%h exp=%h", mEdge, seg, expSeg); end
      if (pos % DIGIT >= BLK) begin
        checks++;
        if (seg !== cSeg[pos / DIGIT]) begin errors++; $display("[TB] FAIL dp_const pos=%0d got=%h exp=%h", pos, seg, cSeg[pos / DIGIT]); end
      end
    end
  endtask

  task automatic test_blank();
    int pos;
    advanceTo(FRAME - 1);
    applyStimulus(1'b1, 16'h1A3F, 4'h0, 4'b1000);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      pos = mEdge % FRAME;
      checks += 2;
      if (an !== expAn) begin errors++; $display("[TB] FAIL blank_an edge=%0d got=%h exp=%h", mEdge, an, expAn); end
      if (seg !== expSeg) begin errors++; $display("[TB] FAIL blank_seg edge=%0d got=%h exp=%h", mEdge, seg, expSeg); end
      if (pos >= 3 * DIGIT) begin
        checks++;
        if ({an, seg} !== {4'hF, 8'hFF}) begin errors++; $display("[TB] FAIL blank_slot3 pos=%0d got=%h/%h exp=f/ff", pos, an, seg); end
      end
      if (pos == BLK) begin
        checks++;
        if ({an, seg} !== {4'b1110, 8'h8E}) begin errors++; $display("[TB] FAIL blank_period pos=%0d got=%h/%h exp=e/8e", pos, an, seg); end
      end
    end
  endtask

  task automatic test_midframe_load();
    int pos;
    advanceTo(FRAME - 1);
    applyStimulus(1'b1, 16'h1A3F, 4'h0, 4'h0);
    advanceTo(DIGIT + BLK);
    applyStimulus(1'b1, 16'h0000, 4'h0, 4'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      pos = mEdge % FRAME;
      checks += 2;
      if (an !== expAn) begin errors++; $display("[TB] FAIL mid_an edge=%0d got=%h exp=%h", mEdge, an, expAn); end
      if (seg !== expSeg) begin errors++; $display("[TB] FAIL mid_seg edge=%0d got=%h exp=%h", mEdge, seg, expSeg); end
      if (i < FRAME - (DIGIT + BLK + 1) && pos == 2 * DIGIT + BLK) begin
        checks++;
        if (seg !== 8'h88) begin errors++; $display("[TB] FAIL mid_old2 got=%h exp=88", seg); end
      end
      if (i < FRAME - (DIGIT + BLK + 1) && pos == 3 * DIGIT + BLK) begin
        checks++;
        if (seg !== 8'hF9) begin errors++; $display("[TB] FAIL mid_old3 got=%h exp=f9", seg); end
      end
      if (i >= FRAME && pos % DIGIT >= BLK) begin
        checks++;
        if (seg !== 8'hC0) begin errors++; $display("[TB] FAIL mid_new pos=%0d got=%h exp=c0", pos, seg); end
      end
    end
  endtask

  task automatic test_bypass();
    int pos;
    advanceTo(FRAME - 1);
    applyStimulus(1'b1, 16'h5555, 4'h0, 4'h0);
    for (int i = 0; i < FRAME - 1; i++) begin
      idle();
      pos = mEdge % FRAME;
      checks += 2;
      if (an !== expAn) begin errors++; $display("[TB] FAIL bypass_an edge=%0d got=%h exp=%h", mEdge, an, expAn); end
      if (seg !== expSeg) begin errors++; $display("[TB] FAIL bypass_seg edge=%0d got=%h exp=%h", mEdge, seg, expSeg); end
      if (pos % DIGIT >= BLK) begin
        checks++;
        if (seg !== 8'h92) begin errors++; $display("[TB] FAIL bypass_same_frame pos=%0d got=%h exp=92", pos, seg); end
      end
    end
  endtask

  task automatic test_sweep();
    int pos;
    for (int v = 0; v < 16; v++) begin
      advanceTo(FRAME - 1);
      applyStimulus(1'b1, {12'($urandom), 4'(v)}, 4'($urandom), 4'($urandom) & 4'b1110);
      for (int i = 0; i < FRAME; i++) begin
        idle();
        pos = mEdge % FRAME;
        checks += 3;
        if (an !== expAn) begin errors++; $display("[TB] FAIL sweep_an v=%0d edge=%0d got=%h exp=%h", v, mEdge, an, expAn); end
        if (seg !== expSeg) begin errors++; $display("[TB] FAIL sweep_seg v=%0d edge=%0d got=%h exp=%h", v, mEdge, seg, expSeg); end
        if ($countones(~an) > 1) begin errors++; $display("[TB] FAIL sweep_onehot got=%b exp=at_most_one_low", an); end
        if (pos >= BLK && pos < DIGIT) begin
          checks++;
          if (seg[6:0] !== segTab[v][6:0]) begin errors++; $display("[TB] FAIL sweep_decode v=%0d got=%h exp=%h", v, seg[6:0], segTab[v][6:0]); end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        applyStimulus(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        idle();
      checks += 3;
      if (an !== expAn) begin errors++; $display("[TB] FAIL random_an edge=%0d got=%h exp=%h", mEdge, an, expAn); end
      if (seg !== expSeg) begin errors++; $display("[TB] FAIL random_seg edge=%0d got=%h exp=%h", mEdge, seg, expSeg); end
      if ($countones(~an) > 1) begin errors++; $display("[TB] FAIL random_onehot got=%b exp=at_most_one_low", an); end
    end
  endtask

  task automatic test_async_reset();
    bit lit = 1'b0;
    advanceTo(FRAME - 1);
    applyStimulus(1'b1, 16'h1A3F, 4'h0, 4'h0);
    for (int i = 0; i < FRAME && !lit; i++) begin
      idle();
      lit = (expAn !== 4'hF);
    end
    checks++;
    if (!lit || an === 4'hF) begin errors++; $display("[TB] FAIL arst_setup got=%h exp=lit_digit", an); end
    #1;
    rst = 1'b1;
    #1;
    checks += 2;
    if (an !== 4'hF) begin errors++; $display("[TB] FAIL arst_an got=%h exp=f", an); end
    if (seg !== 8'hFF) begin errors++; $display("[TB] FAIL arst_seg got=%h exp=ff", seg); end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < FRAME; i++) begin
      idle();
      checks += 2;
      if (an !== expAn) begin errors++; $display("[TB] FAIL arst_after_an edge=%0d got=%h exp=%h", mEdge, an, expAn); end
      if (seg !== expSeg) begin errors++; $display("[TB] FAIL arst_after_seg edge=%0d got=%h exp=%h", mEdge, seg, expSeg); end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_pattern();
    test_dp();
    test_blank();
    test_midframe_load();
    test_bypass();
    test_sweep();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Downstream display stage for the ALU/result logic. Takes four 4-bit hex nibbles plus per-digit decimal-point and blank masks and time-multiplexes them onto a 4-digit common-anode seven-segment display. Only one anode is driven at a time, with a dark guard interval between digits to prevent ghosting. Segment encoding and polarity match the existing single-digit decoder: active-low, seg[7] = DP.

Parameters:
ON_CYCLES, 95000, clocks each digit is lit (>=1)
BLANK_CYCLES, 5000, dark guard clocks before each digit (>=0; 0 removes guard state)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
load  in  1  single-cycle strobe; capture digits_in/dp_in/blank_in
digits_in  in  16  nibble k = digits_in[4k+3:4k] shown on an[k]
dp_in  in  4  dp_in[k]=1 lights DP of digit k
blank_in  in  4  blank_in[k]=1 keeps digit k dark
an  out  4  anode enables, active-low, registered
seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}, registered

Behaviour:
- One clock, one reset: async active-high rst, all state on posedge clk.
- Reset values: an=4'b1111, seg=8'hFF, state=S_BLANK (S_ON if BLANK_CYCLES=0), idx=0, cycle counter=0, shadow and active data=0, shadow and active blank=4'b1111 (display dark until first load reaches active), pending=0. Reset takes effect immediately, including mid-digit.
- Double buffer: load captures inputs into shadow on the next edge and sets pending. Active registers drive the display.
- Frame boundary is the edge where idx wraps 3->0. At that edge, if pending=1, shadow is copied to active and pending is cleared.
- If load and the frame boundary fall on the same edge, active takes digits_in/dp_in/blank_in directly (bypass), and shadow takes the same values.
- A load mid-frame never changes the frame in progress. Repeated loads before a boundary: the last one wins.
- FSM:
  - S_BLANK: an=1111, seg=FF for BLANK_CYCLES clocks, then S_ON.
  - S_ON: lasts ON_CYCLES clocks. At the end, idx=(idx+1) mod 4 and the FSM moves to S_BLANK. With BLANK_CYCLES=0 it stays in S_ON.
- S_ON outputs:
  - an = ~(4'b0001<<idx) unless active blank[idx]=1, in which case an=1111 and seg=FF.
  - Otherwise seg[6:0] = decode(active nibble idx) and seg[7] = ~active dp[idx].
  - Slot timing is unchanged by blanking.
- Outputs are registered from next-state/next-idx so an and seg change together. There are no glitches and never two anodes low.
- Decode table (seg with DP off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Digit period = ON_CYCLES+BLANK_CYCLES. Frame = 4x digit period. Defaults at 100 MHz: 1 ms/digit, 250 Hz frame.
- Counter width = $clog2(max(ON_CYCLES,BLANK_CYCLES)+1). The counter resets to 0 on every state change and never wraps mid-state.
- Latency from load to visible: at most 1 frame + 1 clock. First lit digit after a boundary is always digit 0.

Decomposition:
- Package seven_seg_pkg:
  - SEG_HEX[0:15] constant table
  - SEG_OFF=8'hFF, AN_OFF=4'hF
  - state enum {S_BLANK, S_ON}
- Sub-module hex_to_seg: combinational 4-bit to 7-bit active-low decoder using the package table. It is reusable by the single-digit path.

Test Plan (ON_CYCLES=4, BLANK_CYCLES=2):
1. rst high 3 clocks then low, no load -> an=1111, seg=FF continuously for 3 full frames (72 clocks); rst asserted between edges forces an=1111 with no clock edge.
2. load digits_in=16'h1A3F, dp_in=0, blank_in=0 -> from next boundary, repeating per frame:
   - 2 clocks an=1111/seg=FF
   - 4 clocks an=1110/seg=8E
   - 2 dark clocks
   - 4 clocks an=1101/seg=B0
   - 2 dark clocks
   - 4 clocks an=1011/seg=88
   - 2 dark clocks
   - 4 clocks an=0111/seg=F9
3. Same digits, dp_in=4'b0101 -> digit0 seg=0E, digit2 seg=08; digits 1 and 3 unchanged.
4. blank_in=4'b1000 -> the digit-3 slot shows an=1111/seg=FF for the full 4 clocks; frame length stays 24 clocks.
5. load 16'h0000 while digit 1 is lit -> digits 2 and 3 still show A and 1; next frame shows C0 on all digits. load asserted on the boundary edge -> new value shown in that same frame (bypass).
6. Sweep all 16 nibble values through digit 0 -> seg matches the decode table; at every sampled cycle an has at most one zero bit.
